// File: rtl/apb_master_arbiter.sv
// APB3 master shared by two requesters under round-robin arbitration; all outputs registered.
// Zero-wait transfer acks three cycles after req is seen in IDLE; each pready=0 cycle adds one.
module apb_master_arbiter #(
  parameter int NSLV    = 8,
  parameter int TIMEOUT = 255,
  parameter int SELW    = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_req,
  input  logic            m0_write,
  input  logic [SELW-1:0] m0_sel,
  input  logic [31:0]     m0_addr,
  input  logic [31:0]     m0_wdata,
  output logic            m0_ack,
  output logic            m0_err,
  output logic [31:0]     m0_rdata,
  input  logic            m1_req,
  input  logic            m1_write,
  input  logic [SELW-1:0] m1_sel,
  input  logic [31:0]     m1_addr,
  input  logic [31:0]     m1_wdata,
  output logic            m1_ack,
  output logic            m1_err,
  output logic [31:0]     m1_rdata,
  output logic [NSLV-1:0] psel,
  output logic            penable,
  output logic            pwrite,
  output logic [31:0]     paddr,
  output logic [31:0]     pwdata,
  input  logic            pready,
  input  logic [31:0]     prdata,
  output logic            busy
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  state_t          r_state;
  logic            r_last;
  logic            r_gnt;
  logic [CW-1:0]   r_cnt;

  logic            w_any;
  logic            w_g;
  logic            w_write;
  logic [SELW-1:0] w_sel;
  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic            w_bad;
  logic            w_tmo;
  logic [NSLV-1:0] w_onehot;
  logic            w_fin;
  logic            w_fin_g;
  logic            w_fin_err;
  logic [31:0]     w_fin_rdata;

  // On a tie the requester that did not win last time is granted.
  assign w_any    = m0_req | m1_req;
  assign w_g      = (m0_req & m1_req) ? ~r_last : m1_req;
  assign w_write  = w_g ? m1_write : m0_write;
  assign w_sel    = w_g ? m1_sel   : m0_sel;
  assign w_addr   = w_g ? m1_addr  : m0_addr;
  assign w_wdata  = w_g ? m1_wdata : m0_wdata;
  assign w_bad    = 32'(w_sel) >= 32'(NSLV);
  assign w_onehot = NSLV'(1) << w_sel;
  assign w_tmo    = (TIMEOUT != 0) && (32'(r_cnt) == 32'(TIMEOUT - 1));

  // Transfer completes on this edge: bad select from IDLE, or ready/timeout in ACCESS.
  assign w_fin       = ((r_state == S_IDLE) && w_any && w_bad) ||
                       ((r_state == S_ACCESS) && (pready || w_tmo));
  assign w_fin_g     = (r_state == S_IDLE) ? w_g : r_gnt;
  assign w_fin_err   = (r_state == S_IDLE) ? 1'b1 : ~pready;
  assign w_fin_rdata = ((r_state == S_ACCESS) && pready && !pwrite) ? prdata : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_gnt    <= 1'b0;
      r_cnt    <= '0;
      psel     <= '0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= 32'h0;
      pwdata   <= 32'h0;
      busy     <= 1'b0;
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= 32'h0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= 32'h0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_last <= w_g;
            r_gnt  <= w_g;
            pwrite <= w_write;
            paddr  <= w_addr;
            pwdata <= w_wdata;
            busy   <= 1'b1;
            if (w_bad) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_SETUP;
              psel    <= w_onehot;
            end
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_fin) begin
            r_state <= S_DONE;
            psel    <= '0;
            penable <= 1'b0;
          end else if (r_cnt != CW'(TIMEOUT)) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
      // Response lands in DONE; the other requester's rdata/err are left untouched.
      if (w_fin) begin
        if (w_fin_g) begin
          m1_ack   <= 1'b1;
          m1_err   <= w_fin_err;
          m1_rdata <= w_fin_rdata;
        end else begin
          m0_ack   <= 1'b1;
          m0_err   <= w_fin_err;
          m0_rdata <= w_fin_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: vector table, hand sequences and randomized rounds against a
// transaction-level model (grant order, phase timeline, response values, held results).
module tb_apb_master_arbiter;

  localparam int TMO = 255;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_write, m0_ack, m0_err;
  logic [3:0]  m0_sel;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_write, m1_ack, m1_err;
  logic [3:0]  m1_sel;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [7:0]  psel;
  logic        penable, pwrite, pready, busy;
  logic [31:0] paddr, pwdata, prdata;

  apb_master_arbiter #(.NSLV(8), .TIMEOUT(TMO), .SELW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_write(m0_write), .m0_sel(m0_sel), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_sel(m1_sel), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  string ctx = "";

  // Model state: who won last, and each requester's last reported result.
  bit          model_last;
  bit          held_err [2];
  logic [31:0] held_rd  [2];

  // Per-requester command for the randomized and fairness rounds.
  bit          cw    [2];
  logic [3:0]  csel  [2];
  logic [31:0] caddr [2];
  logic [31:0] cwd   [2];
  logic [31:0] cprd  [2];
  int          cwait [2];

  typedef struct {
    bit          g;
    bit          wr;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prd;
    int          waits;
    bit          eerr;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0h expected %0h", ctx, name, act, exp);
    end
  endtask

  function automatic logic ack_of(input bit g);
    return g ? m1_ack : m0_ack;
  endfunction
  function automatic logic err_of(input bit g);
    return g ? m1_err : m0_err;
  endfunction
  function automatic logic [31:0] rd_of(input bit g);
    return g ? m1_rdata : m0_rdata;
  endfunction

  task automatic set_cmd(input bit g, input bit wr, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (g) begin
      m1_write = wr; m1_sel = sel; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_write = wr; m0_sel = sel; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  // Entered in an IDLE cycle with g's request visible; leaves in the IDLE cycle after DONE.
  task automatic serve(input bit g, input bit wr, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] prd, input int waits,
                       input bit eerr, input logic [31:0] erd);
    logic [7:0] oh;
    int         nacc;
    oh = 8'h1 << sel;
    @(posedge clk); #1;
    if (sel < 4'd8) begin
      chk("setup psel", psel, oh);
      chk("setup penable", penable, 0);
      chk("setup pwrite", pwrite, wr);
      chk("setup paddr", paddr, addr);
      chk("setup pwdata", pwdata, wdata);
      chk("setup busy", busy, 1);
      chk("setup ack", ack_of(g), 0);
      @(posedge clk); #1;
      nacc = (waits >= TMO) ? TMO : waits + 1;
      for (int i = 0; i < nacc; i++) begin
        chk("access penable", penable, 1);
        chk("access psel", psel, oh);
        chk("access ack", ack_of(g), 0);
        pready = (i == waits);
        prdata = (i == waits) ? prd : ~prd;
        @(posedge clk); #1;
      end
      pready = 1'b0;
    end
    chk("done ack", ack_of(g), 1);
    chk("done err", err_of(g), eerr);
    chk("done rdata", rd_of(g), erd);
    chk("done psel", psel, 0);
    chk("done penable", penable, 0);
    chk("done busy", busy, 1);
    chk("other ack", ack_of(~g), 0);
    chk("other err held", err_of(~g), held_err[~g]);
    chk("other rdata held", rd_of(~g), held_rd[~g]);
    held_err[g] = eerr;
    held_rd[g]  = erd;
    if (g) m1_req = 1'b0; else m0_req = 1'b0;
    @(posedge clk); #1;
    chk("idle ack", ack_of(g), 0);
    chk("idle busy", busy, 0);
    chk("idle rdata held", rd_of(g), erd);
  endtask

  task automatic serve_model(input bit g);
    bit          e;
    logic [31:0] r;
    e = (csel[g] >= 4'd8) || (cwait[g] >= TMO);
    r = (e || cw[g]) ? 32'h0 : cprd[g];
    serve(g, cw[g], csel[g], caddr[g], cwd[g], cprd[g], cwait[g], e, r);
  endtask

  task automatic do_round(input bit r0, input bit r1);
    bit first;
    set_cmd(0, cw[0], csel[0], caddr[0], cwd[0]);
    set_cmd(1, cw[1], csel[1], caddr[1], cwd[1]);
    m0_req = r0;
    m1_req = r1;
    if (r0 && r1) begin
      first = ~model_last;
      serve_model(first);
      serve_model(~first);
      model_last = ~first;
    end else begin
      first = r1;
      serve_model(first);
      model_last = first;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 4'd2, 32'h10,   32'h0,        32'hCAFEBABE, 0,   1'b0, 32'hCAFEBABE};
    tbl[1] = '{1'b1, 1'b0, 4'd7, 32'h2000, 32'h0,        32'h12345678, 3,   1'b0, 32'h12345678};
    tbl[2] = '{1'b0, 1'b1, 4'd0, 32'h44,   32'hDEAD0001, 32'hFFFF0000, 1,   1'b0, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 4'd9, 32'h80,   32'h0,        32'h55555555, 0,   1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 4'd8, 32'h84,   32'h0,        32'h66666666, 0,   1'b1, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 4'd5, 32'h300,  32'hBEEF0005, 32'h77777777, 300, 1'b1, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 4'd1, 32'h400,  32'h0,        32'hA5A5A5A5, 254, 1'b0, 32'hA5A5A5A5};
    tbl[7] = '{1'b1, 1'b0, 4'd3, 32'h500,  32'h0,        32'h0BADF00D, 255, 1'b1, 32'h0};

    rst_n = 1'b0; pready = 1'b0; prdata = 32'h0;
    m0_req = 1'b0; m1_req = 1'b0;
    set_cmd(0, 1'b0, 4'd0, 32'h0, 32'h0);
    set_cmd(1, 1'b0, 4'd0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    ctx = "reset";
    chk("psel", psel, 0);        chk("penable", penable, 0);
    chk("pwrite", pwrite, 0);    chk("paddr", paddr, 0);
    chk("pwdata", pwdata, 0);    chk("busy", busy, 0);
    chk("m0_ack", m0_ack, 0);    chk("m0_err", m0_err, 0);    chk("m0_rdata", m0_rdata, 0);
    chk("m1_ack", m1_ack, 0);    chk("m1_err", m1_err, 0);    chk("m1_rdata", m1_rdata, 0);
    model_last = 1'b1;
    held_err[0] = 1'b0; held_err[1] = 1'b0;
    held_rd[0] = 32'h0; held_rd[1] = 32'h0;
    rst_n = 1'b1;

    // Simultaneous writes straight after reset: m0, m1, then m0 again.
    ctx = "fair";
    cw[0] = 1'b1; csel[0] = 4'd1; caddr[0] = 32'hA0; cwd[0] = 32'h11110000; cprd[0] = 32'h0; cwait[0] = 0;
    cw[1] = 1'b1; csel[1] = 4'd6; caddr[1] = 32'hB0; cwd[1] = 32'h22220000; cprd[1] = 32'h0; cwait[1] = 1;
    do_round(1'b1, 1'b1);
    cwd[0] = 32'h11110001; cwd[1] = 32'h22220001; cwait[0] = 2; cwait[1] = 0;
    do_round(1'b1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      ctx = $sformatf("vec%0d", i);
      set_cmd(tbl[i].g, tbl[i].wr, tbl[i].sel, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].g) m1_req = 1'b1; else m0_req = 1'b1;
      serve(tbl[i].g, tbl[i].wr, tbl[i].sel, tbl[i].addr, tbl[i].wdata, tbl[i].prd,
            tbl[i].waits, tbl[i].eerr, tbl[i].erd);
      model_last = tbl[i].g;
    end

    // Reset while a read is stalled in ACCESS.
    ctx = "midreset";
    set_cmd(0, 1'b0, 4'd3, 32'h600, 32'h0);
    m0_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("penable before reset", penable, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("psel", psel, 0);
    chk("penable", penable, 0);
    chk("busy", busy, 0);
    chk("m0_ack", m0_ack, 0);
    chk("m1_rdata", m1_rdata, 0);
    m0_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("no late ack", m0_ack, 0);
    chk("still idle", busy, 0);
    model_last = 1'b1;
    held_err[0] = 1'b0; held_err[1] = 1'b0;
    held_rd[0] = 32'h0; held_rd[1] = 32'h0;

    for (int r = 0; r < 80; r++) begin
      int pick;
      ctx = $sformatf("rnd%0d", r);
      pick = $urandom_range(1, 3);
      for (int g = 0; g < 2; g++) begin
        cw[g]    = 1'($urandom_range(0, 1));
        csel[g]  = 4'($urandom_range(0, 9));
        caddr[g] = $urandom;
        cwd[g]   = $urandom;
        cprd[g]  = $urandom;
        cwait[g] = ($urandom_range(0, 19) == 0) ? $urandom_range(254, 258) : $urandom_range(0, 3);
      end
      do_round(pick[0], pick[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
